// File: rtl/correlator_pkg.sv
// Shared sizing helpers, pair enumeration and readout state type for the
// multi-lag coincidence correlator.
package correlator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } readout_state_t;

    function automatic int calc_num_lags(input int max_lag);
        return 2 * max_lag + 1;
    endfunction

    function automatic int calc_num_pairs(input int num_inputs);
        return (num_inputs * (num_inputs - 1)) / 2;
    endfunction

    function automatic int calc_num_words(input int num_inputs, input int max_lag);
        return calc_num_pairs(num_inputs) * calc_num_lags(max_lag);
    endfunction

    // A single-word frame still needs a one-bit index port
    function automatic int calc_idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    // First channel of pair p in the order (0,1),(0,2)..(0,N-1),(1,2)..
    function automatic int pair_i(input int p, input int num_inputs);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int i = 0; i < num_inputs - 1; i++) begin
            for (int j = i + 1; j < num_inputs; j++) begin
                if (cnt == p) res = i;
                cnt++;
            end
        end
        return res;
    endfunction

    // Second channel of pair p in the same order
    function automatic int pair_j(input int p, input int num_inputs);
        int cnt;
        int res;
        cnt = 0;
        res = 0;
        for (int i = 0; i < num_inputs - 1; i++) begin
            for (int j = i + 1; j < num_inputs; j++) begin
                if (cnt == p) res = j;
                cnt++;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pair_lag_counter.sv
// One channel pair's bank of saturating coincidence counters, one per lag,
// with a snapshot register bank that holds the last closed period.
module pair_lag_counter #(
    parameter int NUM_LAGS   = 9,
    parameter int RESOLUTION = 20
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 count_en,
    input  logic [NUM_LAGS-1:0]                  hits,
    input  logic                                 clear,
    input  logic                                 capture,
    output logic [NUM_LAGS-1:0][RESOLUTION-1:0]  snapshot
);

    logic [NUM_LAGS-1:0][RESOLUTION-1:0] count;
    logic [NUM_LAGS-1:0][RESOLUTION-1:0] count_next;

    // Saturating increment; the snapshot takes this value so a hit landing in
    // the capture cycle still belongs to the closing period
    always_comb begin
        count_next = count;
        for (int l = 0; l < NUM_LAGS; l++) begin
            if (count_en && hits[l] && (count[l] != {RESOLUTION{1'b1}})) begin
                count_next[l] = count[l] + RESOLUTION'(1);
            end
        end
    end

    // Counters restart on every period boundary; snapshot only when allowed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            snapshot <= '0;
        end else begin
            if (clear) count <= '0;
            else       count <= count_next;
            if (capture) snapshot <= count_next;
        end
    end

endmodule

// File: rtl/multi_lag_correlator.sv
// N-channel, symmetric-lag coincidence correlator: synchronises the pulse
// inputs, keeps a short sample history per channel, counts pair/lag
// coincidences per integration period and streams the snapshot out.
module multi_lag_correlator
    import correlator_pkg::*;
#(
    parameter  int NUM_INPUTS = 10,
    parameter  int MAX_LAG    = 4,
    parameter  int RESOLUTION = 20,
    localparam int NUM_LAGS   = calc_num_lags(MAX_LAG),
    localparam int NUM_PAIRS  = calc_num_pairs(NUM_INPUTS),
    localparam int NUM_WORDS  = calc_num_words(NUM_INPUTS, MAX_LAG),
    localparam int IDX_W      = calc_idx_width(NUM_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_INPUTS-1:0] in,
    input  logic                  sample_clk_pulse,
    input  logic                  integration_clk_pulse,
    output logic [RESOLUTION-1:0] out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overrun,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [NUM_INPUTS-1:0]                           sync1;
    logic [NUM_INPUTS-1:0]                           sync2;
    logic [NUM_INPUTS-1:0][NUM_LAGS-1:0]             taps;
    logic                                            sample_d;
    logic [NUM_PAIRS-1:0][NUM_LAGS-1:0][RESOLUTION-1:0] pair_snap;
    logic [NUM_WORDS-1:0][RESOLUTION-1:0]            snap_words;

    readout_state_t   state;
    readout_state_t   state_next;
    logic [IDX_W-1:0] word_idx;
    logic [IDX_W-1:0] word_idx_next;
    logic             capture;
    logic             clear;

    // Two-flop synchroniser on the asynchronous pulse inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Per-channel history, tap 0 newest; the delayed strobe makes the counters
    // evaluate the freshly shifted taps exactly once per sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taps     <= '0;
            sample_d <= 1'b0;
        end else begin
            sample_d <= sample_clk_pulse;
            if (sample_clk_pulse) begin
                for (int ch = 0; ch < NUM_INPUTS; ch++) begin
                    taps[ch][0] <= sync2[ch];
                    for (int k = 1; k < NUM_LAGS; k++) begin
                        taps[ch][k] <= taps[ch][k-1];
                    end
                end
            end
        end
    end

    assign clear   = integration_clk_pulse;
    assign capture = integration_clk_pulse && (state == ST_IDLE);

    // Lag index l compares channel i at the window centre against channel j
    // shifted by d = l - MAX_LAG (positive d: j fires later)
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        localparam int PI = pair_i(p, NUM_INPUTS);
        localparam int PJ = pair_j(p, NUM_INPUTS);
        logic [NUM_LAGS-1:0] hits;

        for (genvar l = 0; l < NUM_LAGS; l++) begin : g_lag
            assign hits[l] = taps[PI][MAX_LAG] & taps[PJ][2*MAX_LAG-l];
        end

        pair_lag_counter #(
            .NUM_LAGS   (NUM_LAGS),
            .RESOLUTION (RESOLUTION)
        ) u_counter (
            .clk      (clk),
            .rst_n    (rst_n),
            .count_en (sample_d),
            .hits     (hits),
            .clear    (clear),
            .capture  (capture),
            .snapshot (pair_snap[p])
        );
    end

    assign snap_words = pair_snap;
    assign out_index  = word_idx;
    assign out_data   = out_valid ? snap_words[word_idx] : '0;

    // Readout state and word pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            word_idx <= '0;
        end else begin
            state    <= state_next;
            word_idx <= word_idx_next;
        end
    end

    // Frame sequencing: one word per accepted handshake, back to idle after last
    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        out_valid     = 1'b0;
        out_last      = 1'b0;
        busy          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (integration_clk_pulse) begin
                    state_next    = ST_SEND;
                    word_idx_next = '0;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (word_idx == LAST_IDX);
                if (out_ready) begin
                    if (word_idx == LAST_IDX) begin
                        state_next    = ST_IDLE;
                        word_idx_next = '0;
                    end else begin
                        word_idx_next = word_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_next    = ST_IDLE;
                word_idx_next = '0;
            end
        endcase
    end

    // A period closed while a frame is still going out is lost; remember that
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (integration_clk_pulse && (state == ST_SEND)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multi_lag_correlator.sv
// Directed bench for multi_lag_correlator (3 channels, MAX_LAG 2, 8-bit counts)
// with a sample-history reference model feeding an expected-word scoreboard.
module tb_multi_lag_correlator;

    localparam int N     = 3;
    localparam int ML    = 2;
    localparam int RES   = 8;
    localparam int LAGS  = 2 * ML + 1;
    localparam int PAIRS = 3;
    localparam int WORDS = PAIRS * LAGS;
    localparam int IW    = 4;

    typedef struct {
        logic [RES-1:0] data;
        logic [IW-1:0]  index;
        logic           last;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_bus;
    logic           sample_clk_pulse;
    logic           integration_clk_pulse;
    logic [RES-1:0] out_data;
    logic [IW-1:0]  out_index;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           overrun;
    logic           busy;

    int tests = 0;
    int fails = 0;

    exp_t           sb[$];
    logic [N-1:0]   hist[LAGS];
    int             cnt[WORDS];
    logic [RES-1:0] got[WORDS];
    bit             model_busy;
    logic           exp_overrun;
    int             pi_tab[PAIRS] = '{0, 0, 1};
    int             pj_tab[PAIRS] = '{1, 2, 2};

    multi_lag_correlator #(
        .NUM_INPUTS (N),
        .MAX_LAG    (ML),
        .RESOLUTION (RES)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in                    (in_bus),
        .sample_clk_pulse      (sample_clk_pulse),
        .integration_clk_pulse (integration_clk_pulse),
        .out_data              (out_data),
        .out_index             (out_index),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_last              (out_last),
        .overrun               (overrun),
        .busy                  (busy)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Hard stop in case the sequence itself stalls
    initial begin
        #600000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < LAGS; k++) hist[k] = '0;
        for (int w = 0; w < WORDS; w++) cnt[w] = 0;
        sb.delete();
        model_busy  = 1'b0;
        exp_overrun = 1'b0;
    endtask

    // Reference: channel i at the window centre against channel j d samples later
    task automatic model_sample(input logic [N-1:0] vec);
        for (int k = LAGS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = vec;
        for (int p = 0; p < PAIRS; p++) begin
            for (int l = 0; l < LAGS; l++) begin
                int d;
                d = l - ML;
                if (hist[ML][pi_tab[p]] && hist[ML-d][pj_tab[p]] && cnt[p*LAGS+l] < 255)
                    cnt[p*LAGS+l]++;
            end
        end
    endtask

    // Hold a pattern long enough to pass the synchroniser, then take one sample
    task automatic apply_stimulus(input logic [N-1:0] vec);
        in_bus = vec;
        repeat (3) next_cycle();
        sample_clk_pulse = 1'b1;
        next_cycle();
        sample_clk_pulse = 1'b0;
        next_cycle();
        model_sample(vec);
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) apply_stimulus('0);
    endtask

    task automatic integrate();
        bit was_busy;
        was_busy = model_busy;
        integration_clk_pulse = 1'b1;
        if (!model_busy) begin
            for (int w = 0; w < WORDS; w++) begin
                exp_t e;
                e.data  = RES'(cnt[w]);
                e.index = IW'(w);
                e.last  = (w == WORDS - 1);
                sb.push_back(e);
            end
            model_busy = 1'b1;
        end else begin
            exp_overrun = 1'b1;
        end
        for (int w = 0; w < WORDS; w++) cnt[w] = 0;
        next_cycle();
        integration_clk_pulse = 1'b0;
        if (!was_busy) begin
            check("valid_after_integrate", 32'(out_valid), 32'd1);
            check("index_after_integrate", 32'(out_index), 32'd0);
        end
        check("overrun_after_integrate", 32'(overrun), 32'(exp_overrun));
    endtask

    // Accept n words at continuous ready, scoring each against the queue
    task automatic check_output(input int n, input bit expect_continuous);
        int taken;
        int cycles;
        taken  = 0;
        cycles = 0;
        out_ready = 1'b1;
        while (taken < n && cycles < 200) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("word_data", 32'(out_data), 32'(e.data));
                    check("word_index", 32'(out_index), 32'(e.index));
                    check("word_last", 32'(out_last), 32'(e.last));
                    check("word_busy", 32'(busy), 32'd1);
                    got[e.index] = out_data;
                    if (e.last) model_busy = 1'b0;
                end
                taken++;
            end
            next_cycle();
            cycles++;
        end
        out_ready = 1'b0;
        check("drain_words_taken", 32'(taken), 32'(n));
        if (expect_continuous) check("drain_cycles", 32'(cycles), 32'(n));
    endtask

    initial begin
        rst_n                 = 1'b0;
        in_bus                = '0;
        sample_clk_pulse      = 1'b0;
        integration_clk_pulse = 1'b0;
        out_ready             = 1'b0;
        model_reset();
        repeat (3) next_cycle();

        // Reset values
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        // Zero-lag coincidence on pair (0,1)
        apply_stimulus(3'b011);
        flush(5);
        integrate();
        check_output(WORDS, 1'b1);
        check("zero_lag_word2", 32'(got[2]), 32'd1);
        check("zero_lag_word3", 32'(got[3]), 32'd0);
        check("zero_lag_word7", 32'(got[7]), 32'd0);

        // Channel 1 one sample behind channel 0, three times
        for (int r = 0; r < 3; r++) begin
            apply_stimulus(3'b001);
            apply_stimulus(3'b010);
            flush(2);
        end
        flush(3);
        integrate();
        check_output(WORDS, 1'b1);
        check("plus_one_word3", 32'(got[3]), 32'd3);
        check("plus_one_word2", 32'(got[2]), 32'd0);

        // Saturation on pair (0,2)
        for (int s = 0; s < 300; s++) apply_stimulus(3'b101);
        flush(5);
        integrate();
        check_output(WORDS, 1'b1);
        check("saturate_word7", 32'(got[7]), 32'd255);

        // Backpressure: first word held stable
        apply_stimulus(3'b011);
        flush(5);
        integrate();
        for (int c = 0; c < 10; c++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_index", 32'(out_index), 32'd0);
            check("stall_data", 32'(out_data), 32'(sb[0].data));
            next_cycle();
        end
        check_output(WORDS, 1'b1);

        // Second integration during readout
        apply_stimulus(3'b011);
        flush(5);
        integrate();
        apply_stimulus(3'b111);
        flush(5);
        integrate();
        apply_stimulus(3'b110);
        flush(5);
        check("overrun_sticky", 32'(overrun), 32'd1);
        check_output(WORDS, 1'b1);
        check("overrun_frame_word2", 32'(got[2]), 32'd1);
        integrate();
        check_output(WORDS, 1'b1);
        check("after_overrun_word12", 32'(got[12]), 32'd1);
        check("after_overrun_word2", 32'(got[2]), 32'd0);

        // Reset in the middle of a frame
        apply_stimulus(3'b011);
        flush(5);
        integrate();
        check_output(7, 1'b1);
        check("pre_reset_index", 32'(out_index), 32'd7);
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        check("mid_reset_valid", 32'(out_valid), 32'd0);
        check("mid_reset_busy", 32'(busy), 32'd0);
        check("mid_reset_overrun", 32'(overrun), 32'd0);
        model_reset();
        next_cycle();
        integrate();
        check_output(WORDS, 1'b1);
        check("post_reset_word2", 32'(got[2]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
